fft_bf_sdf: RTL and testbench
=============================

FFT_BF_SDF -- requirements
Module: fft_bf_sdf

Interface
REQ-001 Parameter DELAY, default 8, is the butterfly span in samples; legal values are 1, 2, 4 and 8, and 8 is the first stage of the 16-point FFT.
REQ-002 clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  is the reset; it SHALL be asynchronous and active-low.
REQ-004 in_valid  input  1  SHALL mean a sample is presented this cycle and is accepted unconditionally, with no backpressure.
REQ-005 in_re, in_im  input  16 each  SHALL be the signed two's-complement complex input sample.
REQ-006 out_valid  output  1  SHALL mean out_re, out_im, out_twf and out_tw_idx are valid this cycle.
REQ-007 out_re, out_im  output  17 each  SHALL be the signed butterfly result, sized for the downstream twiddle multiplier's 17-bit data operand.
REQ-008 out_twf  output  1  SHALL be 1 when the result is a difference term that needs twiddle multiplication, and 0 when it is a sum term.
REQ-009 out_tw_idx  output  3  SHALL give the twiddle exponent k of W16^k, range 0..7.

Function
REQ-010 The block SHALL be a radix-2 DIF single-path delay-feedback stage with a DELAY-deep complex FIFO of 17-bit entries.
REQ-011 The block SHALL hold a counter cnt, modulo 2*DELAY, that advances by 1 only on accepted inputs and wraps 2*DELAY-1 -> 0.
REQ-012 Fill phase (cnt < DELAY), on each accept:
- the FIFO head is popped and registered to the outputs with out_twf=1 and out_tw_idx=cnt*(8/DELAY);
- the input, sign-extended to 17 bits, is pushed.
REQ-013 Butterfly phase (cnt >= DELAY), on each accept, with h = FIFO head and x = input:
- out = h + x is registered with out_twf=0 and out_tw_idx=0;
- h - x is pushed.
REQ-014 All arithmetic SHALL be full-precision 17-bit signed, with no rounding, scaling or saturation; the operands are 16-bit values, so the result cannot overflow.
REQ-015 The real and imaginary parts SHALL be processed identically and independently.
REQ-016 Latency: outputs SHALL be registered and appear on the clock edge that accepts the input, visible in the following cycle; there SHALL be no combinational path from input to output.
REQ-017 A primed flag SHALL be 0 after reset and set when cnt wraps DELAY-1 -> DELAY.
REQ-018 out_valid SHALL equal 1 in the cycle after an accept only when primed was 1 at that accept.
- The first DELAY accepted samples after reset therefore produce out_valid=0.
- Fill-phase pops made before primed is set SHALL be discarded.
REQ-019 When in_valid=0:
- cnt, the FIFO and primed SHALL hold;
- out_valid SHALL be 0 the next cycle;
- the data outputs SHALL hold their last values.
REQ-020 Frames SHALL be back-to-back; the last DELAY differences of a frame emerge only while the next frame's (or zero-padding) first DELAY samples are accepted.
REQ-021 Gaps in in_valid of any length, at any cnt value, SHALL NOT alter the output sequence.

Reset
REQ-022 While rst_n=0, every output SHALL be 0: out_valid, out_re, out_im, out_twf and out_tw_idx.
REQ-023 While rst_n=0, cnt=0, primed=0 and every FIFO entry SHALL be 0.
REQ-024 Reset asserted mid-frame SHALL discard all buffered samples; the first accept after release is treated as sample 0 of a new frame.
REQ-025 Release of rst_n SHALL be assumed synchronous to clk by the system.

Verification
REQ-026 DELAY=8, ramp in_re=n for n=0..15, in_im=0, continuous valid, then 8 zeros:
- accepts 0..7 -> out_valid=0;
- accepts 8..15 -> out_re=8,10,...,22, out_twf=0;
- accepts 16..23 -> out_re=-8 each, out_twf=1, out_tw_idx=0..7;
- out_im=0 throughout.
REQ-027 DELAY=8, in_re=in_im=-32768 for 16 samples -> butterfly outputs out_re=out_im=-65536, then differences =0; this is the no-overflow extreme.
REQ-028 Stall: repeat REQ-026 with in_valid toggling 1,0,1,0 and random multi-cycle gaps -> identical output sequence, out_valid=0 in every cycle following a gap cycle.
REQ-029 Reset mid-frame: apply rst_n=0 after 11 accepts, then rerun REQ-026 -> outputs all 0 during reset, then exact REQ-026 results with no residue.
REQ-030 DELAY=1, inputs 5, 3, 0, 0 (real) -> first accept out_valid=0; then 8 (twf=0), then 2 (twf=1, tw_idx=0), then 0 (twf=0).
REQ-031 DELAY=2, inputs 1, 2, 3, 4, 0, 0 -> sums 4, 6, then differences -2 (tw_idx=0) and -2 (tw_idx=4).

Source files
------------

// File: rtl/fft_bf_sdf.sv
// Radix-2 DIF single-path delay-feedback butterfly stage with a DELAY-deep complex FIFO.
// Emits sums during the butterfly half and drains tagged differences during the next fill half.
module fft_bf_sdf #(
    parameter int DELAY = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [15:0] in_re,
    input  logic [15:0] in_im,
    output logic        out_valid,
    output logic [16:0] out_re,
    output logic [16:0] out_im,
    output logic        out_twf,
    output logic [2:0]  out_tw_idx
);
    localparam int CW = $clog2(2 * DELAY);
    localparam int SH = $clog2(8 / DELAY);

    logic [CW-1:0]      cnt;
    logic               primed;
    logic signed [16:0] fre [DELAY];
    logic signed [16:0] fim [DELAY];

    logic signed [16:0] xre, xim, hre, him, pre, pim;
    logic               bfly;
    logic [3:0]         cnt4;
    logic [2:0]         tw;

    assign xre  = {in_re[15], in_re};
    assign xim  = {in_im[15], in_im};
    assign hre  = fre[DELAY-1];
    assign him  = fim[DELAY-1];
    // 2*DELAY is a power of two, so the counter MSB marks the butterfly half
    assign bfly = cnt[CW-1];
    assign cnt4 = 4'(cnt);
    assign tw   = 3'(cnt4 << SH);
    assign pre  = bfly ? (hre - xre) : xre;
    assign pim  = bfly ? (him - xim) : xim;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            primed     <= 1'b0;
            out_valid  <= 1'b0;
            out_re     <= '0;
            out_im     <= '0;
            out_twf    <= 1'b0;
            out_tw_idx <= '0;
            for (int i = 0; i < DELAY; i++) begin
                fre[i] <= '0;
                fim[i] <= '0;
            end
        end else if (in_valid) begin
            cnt       <= cnt + CW'(1);
            out_valid <= primed;
            if (cnt == CW'(DELAY - 1))
                primed <= 1'b1;
            if (bfly) begin
                out_re     <= hre + xre;
                out_im     <= him + xim;
                out_twf    <= 1'b0;
                out_tw_idx <= '0;
            end else begin
                out_re     <= hre;
                out_im     <= him;
                out_twf    <= 1'b1;
                out_tw_idx <= tw;
            end
            fre[0] <= pre;
            fim[0] <= pim;
            for (int i = 1; i < DELAY; i++) begin
                fre[i] <= fre[i-1];
                fim[i] <= fim[i-1];
            end
        end else begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fft_bf_sdf.sv
// Bench for fft_bf_sdf: DELAY=1/2 vector tables plus a frame-level reference model for DELAY=8.
module tb_fft_bf_sdf;
    localparam int D = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        v8 = 0, v2 = 0, v1 = 0;
    logic [15:0] r8 = 0, i8 = 0, r2 = 0, r1 = 0;
    logic        ov8, ov2, ov1, tf8, tf2, tf1;
    logic [16:0] or8, oi8, or2, oi2, or1, oi1;
    logic [2:0]  ti8, ti2, ti1;

    fft_bf_sdf #(.DELAY(8)) u8 (.clk(clk), .rst_n(rst_n), .in_valid(v8), .in_re(r8), .in_im(i8),
        .out_valid(ov8), .out_re(or8), .out_im(oi8), .out_twf(tf8), .out_tw_idx(ti8));
    fft_bf_sdf #(.DELAY(2)) u2 (.clk(clk), .rst_n(rst_n), .in_valid(v2), .in_re(r2), .in_im(16'd0),
        .out_valid(ov2), .out_re(or2), .out_im(oi2), .out_twf(tf2), .out_tw_idx(ti2));
    fft_bf_sdf #(.DELAY(1)) u1 (.clk(clk), .rst_n(rst_n), .in_valid(v1), .in_re(r1), .in_im(16'd0),
        .out_valid(ov1), .out_re(or1), .out_im(oi1), .out_twf(tf1), .out_tw_idx(ti1));

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state for the DELAY=8 instance
    int   sre[$];
    int   sim[$];
    int   l_re, l_im, l_idx;
    logic l_twf;
    logic l_known;

    typedef struct {
        int   dly;
        int   re;
        logic ev;
        int   ere;
        logic etwf;
        int   eidx;
    } vec_t;
    vec_t tbl[10];

    task automatic model_reset();
        sre.delete();
        sim.delete();
        l_re = 0; l_im = 0; l_idx = 0; l_twf = 0; l_known = 1;
    endtask

    task automatic chk_zero(input string name);
        n_cmp++;
        if (ov8 !== 0 || or8 !== 0 || oi8 !== 0 || tf8 !== 0 || ti8 !== 0 ||
            ov2 !== 0 || or2 !== 0 || tf2 !== 0 || ti2 !== 0 ||
            ov1 !== 0 || or1 !== 0 || tf1 !== 0 || ti1 !== 0) begin
            n_bad++;
            $display("FAIL %s: got v8=%0b re8=%0d im8=%0d twf8=%0b idx8=%0d v2=%0b re2=%0d v1=%0b re1=%0d, want all 0",
                     name, ov8, or8, oi8, tf8, ti8, ov2, or2, ov1, or1);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        v8 = 0; v2 = 0; v1 = 0;
        rst_n = 0;
        #2;
        chk_zero("reset_async");
        @(posedge clk); #1;
        chk_zero("reset_held");
        rst_n = 1;
        model_reset();
    endtask

    // Expected output at accept n, from frame arithmetic: sums x[j]+x[j+D] in the second half,
    // differences of the previous frame drained in the first half of the next one.
    task automatic step8(input logic v, input int re, input int im, input string name);
        int   n, p, f, b, j;
        logic ev;
        v8 = v; r8 = 16'(re); i8 = 16'(im);
        @(posedge clk); #1;
        v8 = 0;
        ev = 0;
        if (v) begin
            sre.push_back(re);
            sim.push_back(im);
            n = sre.size() - 1;
            if (n >= D) begin
                ev = 1;
                p  = n % (2 * D);
                f  = n / (2 * D);
                if (p >= D) begin
                    b = f * 2 * D; j = p - D;
                    l_re = sre[b+j] + sre[b+j+D];
                    l_im = sim[b+j] + sim[b+j+D];
                    l_twf = 0; l_idx = 0;
                end else begin
                    b = (f - 1) * 2 * D;
                    l_re = sre[b+p] - sre[b+p+D];
                    l_im = sim[b+p] - sim[b+p+D];
                    l_twf = 1; l_idx = p * (8 / D);
                end
                l_known = 1;
            end else begin
                l_known = 0;
            end
        end
        n_cmp++;
        if (ov8 !== ev ||
            ((ev || (!v && l_known)) &&
             (int'($signed(or8)) != l_re || int'($signed(oi8)) != l_im || tf8 !== l_twf || int'(ti8) != l_idx))) begin
            n_bad++;
            $display("FAIL %s acc=%0d: got v=%0b re=%0d im=%0d twf=%0b idx=%0d, want v=%0b re=%0d im=%0d twf=%0b idx=%0d",
                     name, sre.size(), ov8, $signed(or8), $signed(oi8), tf8, ti8, ev, l_re, l_im, l_twf, l_idx);
        end
    endtask

    task automatic ramp(input string name, input logic gaps);
        for (int k = 0; k < 24; k++) begin
            step8(1'b1, (k < 16) ? k : 0, 0, name);
            if (gaps) begin
                if (k < 8) step8(1'b0, 0, 0, name);
                else if ($urandom_range(0, 1) == 1)
                    for (int g = 0; g < int'($urandom_range(1, 5)); g++) step8(1'b0, 16'hdead, 16'hbeef, name);
            end
        end
    endtask

    initial begin
        logic       gv;
        logic [2:0] gi;
        logic [16:0] gr;
        logic       gt;
        model_reset();
        tbl[0] = '{1, 5, 0, 0, 0, 0};
        tbl[1] = '{1, 3, 1, 8, 0, 0};
        tbl[2] = '{1, 0, 1, 2, 1, 0};
        tbl[3] = '{1, 0, 1, 0, 0, 0};
        tbl[4] = '{2, 1, 0, 0, 0, 0};
        tbl[5] = '{2, 2, 0, 0, 0, 0};
        tbl[6] = '{2, 3, 1, 4, 0, 0};
        tbl[7] = '{2, 4, 1, 6, 0, 0};
        tbl[8] = '{2, 0, 1, -2, 1, 0};
        tbl[9] = '{2, 0, 1, -2, 1, 4};

        repeat (2) @(posedge clk);
        do_reset();

        for (int i = 0; i < 10; i++) begin
            if (tbl[i].dly == 1) begin v1 = 1; r1 = 16'(tbl[i].re); end
            else begin v2 = 1; r2 = 16'(tbl[i].re); end
            @(posedge clk); #1;
            v1 = 0; v2 = 0;
            gv = (tbl[i].dly == 1) ? ov1 : ov2;
            gr = (tbl[i].dly == 1) ? or1 : or2;
            gt = (tbl[i].dly == 1) ? tf1 : tf2;
            gi = (tbl[i].dly == 1) ? ti1 : ti2;
            n_cmp++;
            if (gv !== tbl[i].ev ||
                (tbl[i].ev && (int'($signed(gr)) != tbl[i].ere || gt !== tbl[i].etwf || int'(gi) != tbl[i].eidx))) begin
                n_bad++;
                $display("FAIL table_d%0d row%0d: got v=%0b re=%0d twf=%0b idx=%0d, want v=%0b re=%0d twf=%0b idx=%0d",
                         tbl[i].dly, i, gv, $signed(gr), gt, gi, tbl[i].ev, tbl[i].ere, tbl[i].etwf, tbl[i].eidx);
            end
        end

        do_reset();
        ramp("ramp", 1'b0);

        do_reset();
        for (int k = 0; k < 16; k++) step8(1'b1, -32768, -32768, "extreme");
        for (int k = 0; k < 8; k++) step8(1'b1, 0, 0, "extreme");

        do_reset();
        ramp("stall_ramp", 1'b1);

        do_reset();
        for (int k = 0; k < 11; k++) step8(1'b1, 1000 + 37 * k, -500 + k, "pre_reset");
        do_reset();
        ramp("ramp_after_reset", 1'b0);

        do_reset();
        for (int k = 0; k < 400; k++) begin
            step8(1'b1, int'($signed(16'($urandom))), int'($signed(16'($urandom))), "random");
            if ($urandom_range(0, 3) == 0)
                for (int g = 0; g < int'($urandom_range(1, 4)); g++)
                    step8(1'b0, int'($urandom_range(0, 65535)), 0, "random_gap");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
